// File: rtl/cube_acc_pkg.sv
// Shared types and defaults for the cube frame accumulator.
// Build option CUBE_ACC_SAT_EN is consumed by cube_acc_add only.
package cube_acc_pkg;

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam int DEF_DATA_W    = 24;
  localparam int DEF_FRAME_LEN = 8;

  // Width that holds FRAME_LEN full-scale samples without carry-out.
  function automatic int acc_width(input int data_w, input int frame_len);
    return data_w + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/cube_acc_add.sv
// Combinational accumulator adder with carry-out.
// CUBE_ACC_SAT_EN defined: clamp to all-ones on carry; otherwise wrap modulo 2^ACC_W.
module cube_acc_add #(
  parameter int DATA_W = 24,
  parameter int ACC_W  = 27
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] sample,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  // Wide enough for the zero-extended sample even when ACC_W < DATA_W.
  localparam int FULL_W = ((ACC_W > DATA_W) ? ACC_W : DATA_W) + 1;

  logic [FULL_W-1:0] full;

  always_comb begin
    full  = FULL_W'(acc) + FULL_W'(sample);
    carry = |full[FULL_W-1:ACC_W];
`ifdef CUBE_ACC_SAT_EN
    sum   = carry ? '1 : full[ACC_W-1:0];
`else
    sum   = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/cube_frame_accumulator.sv
// Sums FRAME_LEN cube samples per frame and hands each sum out on a valid/ready port.
// Saturating accumulation is selected by CUBE_ACC_SAT_EN (see cube_acc_add).
module cube_frame_accumulator
  import cube_acc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ACC_W     = acc_width(DATA_W, FRAME_LEN),
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              sum_valid,
  output logic [ACC_W-1:0]  sum_data,
  output logic [CNT_W-1:0]  sum_count,
  output logic              sum_ovf,
  input  logic              sum_ready
);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  logic              accept;
  logic              close;
  logic [DATA_W-1:0] add_in;
  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;
  logic [CNT_W-1:0]  next_count;
  logic              next_ovf;

  // Gated with rst_n so upstream sees no ready while reset is asserted.
  assign in_ready   = rst_n & (state == ACCUM);
  assign accept     = in_valid & in_ready;
  assign add_in     = accept ? in_data : '0;
  assign next_count = count + CNT_W'(accept);
  assign next_ovf   = ovf | (accept & add_carry);
  assign close      = (accept && (next_count == CNT_W'(FRAME_LEN)))
                    || (flush && ((count != '0) || accept));

  cube_acc_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc    (acc),
    .sample (add_in),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_count <= '0;
      sum_ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (close) begin
            sum_data  <= add_sum;
            sum_count <= next_count;
            sum_ovf   <= next_ovf;
            sum_valid <= 1'b1;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            state     <= HOLD;
          end else if (accept) begin
            acc   <= add_sum;
            count <= next_count;
            ovf   <= next_ovf;
          end
        end
        HOLD: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cube_frame_accumulator.sv
// Self-checking bench: dut_a (FRAME_LEN=4, default ACC_W) and dut_b (FRAME_LEN=2, ACC_W=24).
// Expected overflow results follow CUBE_ACC_SAT_EN when it is defined.
module tb_cube_frame_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_in_valid = 1'b0, a_flush = 1'b0, a_sum_ready = 1'b0;
  logic [23:0] a_in_data = '0;
  logic        a_in_ready, a_sum_valid, a_sum_ovf;
  logic [25:0] a_sum_data;
  logic [2:0]  a_sum_count;

  logic        b_in_valid = 1'b0, b_flush = 1'b0, b_sum_ready = 1'b0;
  logic [23:0] b_in_data = '0;
  logic        b_in_ready, b_sum_valid, b_sum_ovf;
  logic [23:0] b_sum_data;
  logic [1:0]  b_sum_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cube_frame_accumulator #(.DATA_W(24), .FRAME_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .flush(a_flush), .sum_valid(a_sum_valid),
    .sum_data(a_sum_data), .sum_count(a_sum_count), .sum_ovf(a_sum_ovf),
    .sum_ready(a_sum_ready)
  );

  cube_frame_accumulator #(.DATA_W(24), .FRAME_LEN(2), .ACC_W(24)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .flush(b_flush), .sum_valid(b_sum_valid),
    .sum_data(b_sum_data), .sum_count(b_sum_count), .sum_ovf(b_sum_ovf),
    .sum_ready(b_sum_ready)
  );

  typedef struct {
    int          n;
    logic [23:0] d0, d1, d2, d3;
    bit          fl;
    bit          gap;
    logic [25:0] es;
    logic [2:0]  ec;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input int d0, input int d1, input int d2,
                              input int d3, input bit fl, input bit gap,
                              input longint es, input int ec);
    vec_t v;
    v.n = n; v.d0 = 24'(d0); v.d1 = 24'(d1); v.d2 = 24'(d2); v.d3 = 24'(d3);
    v.fl = fl; v.gap = gap; v.es = 26'(es); v.ec = 3'(ec);
    return v;
  endfunction

  function automatic logic [23:0] cube(input int unsigned v);
    return 24'(v * v * v);
  endfunction

  // Reference for the 24-bit accumulator: plain sum, then clamp or wrap.
  function automatic logic [24:0] model_b(input longint s);
    longint lim = 64'd1 << 24;
    bit ovf = (s >= lim);
`ifdef CUBE_ACC_SAT_EN
    return {ovf, 24'(ovf ? lim - 1 : s)};
`else
    return {ovf, 24'(s % lim)};
`endif
  endfunction

  task automatic a_send(input logic [23:0] d, input bit fl, input int gap);
    int w = 0;
    a_in_valid = 1'b0; a_flush = 1'b0;
    repeat (gap) @(negedge clk);
    while (!a_in_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) check("a_ready_timeout", a_in_ready, 1);
    a_in_valid = 1'b1; a_in_data = d; a_flush = fl;
    @(negedge clk);
    a_in_valid = 1'b0; a_flush = 1'b0;
  endtask

  task automatic a_expect(input string nm, input logic [25:0] es, input logic [2:0] ec,
                          input bit eo, input int elat);
    int lat = 0;
    while (!a_sum_valid && lat < 40) begin @(negedge clk); lat++; end
    check({nm, "_valid"}, a_sum_valid, 1);
    if (elat >= 0) check({nm, "_latency"}, lat, elat);
    check({nm, "_data"}, a_sum_data, es);
    check({nm, "_count"}, a_sum_count, ec);
    check({nm, "_ovf"}, a_sum_ovf, eo);
    a_sum_ready = 1'b1;
    @(negedge clk);
    a_sum_ready = 1'b0;
    check({nm, "_released"}, a_sum_valid, 0);
  endtask

  task automatic b_frame(input string nm, input logic [23:0] d0, input logic [23:0] d1,
                         input logic [24:0] exp);
    int w;
    logic [23:0] ds [2];
    ds[0] = d0; ds[1] = d1;
    for (int i = 0; i < 2; i++) begin
      w = 0;
      while (!b_in_ready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) check({nm, "_ready_timeout"}, b_in_ready, 1);
      b_in_valid = 1'b1; b_in_data = ds[i];
      @(negedge clk);
      b_in_valid = 1'b0;
    end
    check({nm, "_valid"}, b_sum_valid, 1);
    check({nm, "_data"}, b_sum_data, exp[23:0]);
    check({nm, "_ovf"}, b_sum_ovf, exp[24]);
    check({nm, "_count"}, b_sum_count, 2);
    b_sum_ready = 1'b1;
    @(negedge clk);
    b_sum_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] held;
    longint      ref_sum;
    logic [23:0] d;
    int          n;
    bit          alone;

    tbl[0] = mk(4, 8, 27, 64, 125, 0, 0, 224, 4);
    tbl[1] = mk(2, 1000, 16581375, 0, 0, 1, 0, 16582375, 2);
    tbl[2] = mk(4, 8, 27, 64, 125, 0, 1, 224, 4);
    tbl[3] = mk(1, 16581375, 0, 0, 0, 1, 0, 16581375, 1);
    tbl[4] = mk(4, 16581375, 16581375, 16581375, 16581375, 0, 1, 66325500, 4);
    tbl[5] = mk(3, 0, 0, 1, 0, 1, 0, 1, 3);

    // Reset state while rst_n is held low
    #12;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_sum_valid", a_sum_valid, 0);
    check("rst_sum_data", a_sum_data, 0);
    check("rst_sum_count", a_sum_count, 0);
    check("rst_sum_ovf", a_sum_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", a_in_ready, 1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      logic [23:0] ds [4];
      ds[0] = tbl[i].d0; ds[1] = tbl[i].d1; ds[2] = tbl[i].d2; ds[3] = tbl[i].d3;
      for (int j = 0; j < tbl[i].n; j++)
        a_send(ds[j], tbl[i].fl && (j == tbl[i].n - 1), tbl[i].gap ? (j % 3) + 1 : 0);
      a_expect($sformatf("tbl%0d", i), tbl[i].es, tbl[i].ec, 1'b0, 0);
    end

    // Flush with an empty frame must not emit a sum
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("empty_flush_no_valid", a_sum_valid, 0);
      @(negedge clk);
    end

    // Backpressure: held sum stays stable, input blocked, flush ignored
    a_send(24'd77, 1'b1, 0);
    a_in_valid = 1'b1; a_in_data = 24'd999; a_flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready", a_in_ready, 0);
      check("bp_sum_data", a_sum_data, 77);
      @(negedge clk);
    end
    a_in_valid = 1'b0; a_flush = 1'b0;
    a_expect("bp_frame", 26'd77, 3'd1, 1'b0, 0);
    check("bp_ready_after", a_in_ready, 1);
    a_send(24'd8, 0, 0); a_send(24'd27, 0, 0); a_send(24'd64, 0, 0); a_send(24'd125, 0, 0);
    a_expect("bp_next", 26'd224, 3'd4, 1'b0, 0);

    // Asynchronous reset mid-frame, off the clock edge
    a_send(24'd8, 0, 0); a_send(24'd27, 0, 0);
    held = a_sum_data;
    check("pre_rst_held", held, 224);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_sum_data", a_sum_data, 0);
    check("mid_rst_sum_valid", a_sum_valid, 0);
    check("mid_rst_in_ready", a_in_ready, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    a_send(24'd64, 0, 0); a_send(24'd125, 0, 0); a_send(24'd1000, 0, 0); a_send(24'd8, 0, 0);
    a_expect("after_rst", 26'd1197, 3'd4, 1'b0, 0);

    // Randomized frames against a plain-sum reference
    for (int f = 0; f < 30; f++) begin
      n = int'($urandom_range(1, 4));
      alone = (n < 4) && ($urandom_range(0, 1) == 1);
      ref_sum = 0;
      for (int j = 0; j < n; j++) begin
        d = cube($urandom_range(0, 255));
        ref_sum += longint'(d);
        a_send(d, (n < 4) && !alone && (j == n - 1), int'($urandom_range(0, 2)));
      end
      if (alone) begin
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0;
      end
      a_expect($sformatf("rand%0d", f), 26'(ref_sum), 3'(n), 1'b0, 0);
    end

    // 24-bit accumulator overflow
`ifdef CUBE_ACC_SAT_EN
    b_frame("ovf_fixed", 24'd16581375, 24'd16581375, {1'b1, 24'd16777215});
`else
    b_frame("ovf_fixed", 24'd16581375, 24'd16581375, {1'b1, 24'd16385534});
`endif
    b_frame("b_small", 24'd8, 24'd27, model_b(35));
    for (int f = 0; f < 12; f++) begin
      logic [23:0] x, y;
      x = cube($urandom_range(150, 255));
      y = cube($urandom_range(150, 255));
      b_frame($sformatf("b_rand%0d", f), x, y, model_b(longint'(x) + longint'(y)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
